// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract sequencer: FSM state codes
// and the bit-counter width helper.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must be at least one bit even for the narrowest legal WIDTH.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell, time-shared by serial_add_ctrl across all bit positions.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder cell, WIDTH cycles per op.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_start_ready;
  logic             r_res_valid;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic w_sum;
  logic w_cout;
  logic w_last;

  full_adder u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Sequencer FSM: operand load, serial shift/add, result hold and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_sa          <= '0;
      r_sb          <= '0;
      r_result      <= '0;
      r_cnt         <= '0;
      r_carry       <= 1'b0;
      r_cout        <= 1'b0;
      r_start_ready <= 1'b0;
      r_res_valid   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf         <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid && r_start_ready) begin
            r_sa          <= op_a;
            r_sb          <= sub ? ~op_b : op_b;
            r_carry       <= sub;
            r_cnt         <= '0;
            r_start_ready <= 1'b0;
            r_state       <= ST_RUN;
          end else begin
            r_start_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_result      <= '0;
            r_cout        <= 1'b0;
            r_cnt         <= '0;
            r_start_ready <= 1'b1;
            r_state       <= ST_IDLE;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf         <= 1'b0;
`endif
          end else begin
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
            r_carry  <= w_cout;
            if (w_last) begin
              // r_carry here is the carry into the MSB position.
              r_cout      <= w_cout;
              r_cnt       <= '0;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
              r_ovf       <= r_carry ^ w_cout;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_res_valid <= 1'b1;
          end
        end
        default: begin
          r_res_valid   <= 1'b0;
          r_start_ready <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign res_valid   = r_res_valid;
  assign result      = r_result;
  assign cout        = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf         = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       sub;
  logic       abort;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with res_ready held high; returns result and latency.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [7:0] r, output logic c, output logic v, output int lat);
    int w;
    w = 0;
    while (!start_ready && w < 50) begin
      tick();
      w++;
    end
    check("ready_before_op", 32'(start_ready), 32'd1);
    op_a = a; op_b = b; sub = s; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      tick();
      lat++;
    end
    r = result;
    c = cout;
`ifdef SERIAL_ADD_OVF_EN
    v = ovf;
`else
    v = 1'b0;
`endif
    tick();
  endtask

  initial begin
    logic [7:0] r;
    logic       c;
    logic       v;
    int         lat;
    logic       saw;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] bb;
    logic       rs;
    logic [8:0] exp9;
    logic       exp_ovf;

    rst_n = 1'b0; start_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
    sub = 1'b0; abort = 1'b0; res_ready = 1'b1;

    // Reset state
    #12;
    check("rst_start_ready", 32'(start_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    tick();
    rst_n = 1'b1;
    check("rel_start_ready_low", 32'(start_ready), 32'd0);
    tick();
    check("rel_start_ready_high", 32'(start_ready), 32'd1);

    // 1: basic add and latency
    do_op(8'h0F, 8'h01, 1'b0, r, c, v, lat);
    check("t1_result", 32'(r), 32'h10);
    check("t1_cout", 32'(c), 32'd0);
    check("t1_latency", 32'(lat), 32'd8);

    // 2: wrap and subtract cases
    do_op(8'hFF, 8'h01, 1'b0, r, c, v, lat);
    check("t2a_result", 32'(r), 32'h00);
    check("t2a_cout", 32'(c), 32'd1);
    do_op(8'h05, 8'h07, 1'b1, r, c, v, lat);
    check("t2b_result", 32'(r), 32'hFE);
    check("t2b_cout", 32'(c), 32'd0);
    do_op(8'h07, 8'h05, 1'b1, r, c, v, lat);
    check("t2c_result", 32'(r), 32'h02);
    check("t2c_cout", 32'(c), 32'd1);

    // 3: backpressure in DONE
    res_ready = 1'b0;
    op_a = 8'h3C; op_b = 8'h0A; sub = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("t3_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      op_a = 8'hFF; op_b = 8'hFF; sub = 1'b1; start_valid = 1'b1;
      tick();
      check("t3_hold_valid", 32'(res_valid), 32'd1);
      check("t3_hold_result", 32'(result), 32'h46);
      check("t3_hold_ready", 32'(start_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    start_valid = 1'b0;
    check("t3_drain_valid", 32'(res_valid), 32'd0);
    check("t3_drain_ready", 32'(start_ready), 32'd1);
    check("t3_drain_result", 32'(result), 32'h46);
    tick();
    check("t3_idle_ready", 32'(start_ready), 32'd1);

    // 4: abort mid-run
    op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_valid", 32'(res_valid), 32'd0);
    check("t4_abort_result", 32'(result), 32'd0);
    check("t4_abort_ready", 32'(start_ready), 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw = saw | res_valid;
    end
    check("t4_no_valid", 32'(saw), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, r, c, v, lat);
    check("t4_next_result", 32'(r), 32'h02);
    check("t4_next_latency", 32'(lat), 32'd8);

    // 5: reset during RUN
    op_a = 8'h33; op_b = 8'h11; sub = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(res_valid), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    check("t5_rst_ready", 32'(start_ready), 32'd0);
    check("t5_rst_cout", 32'(cout), 32'd0);
    tick();
    rst_n = 1'b1;
    do_op(8'h10, 8'h20, 1'b0, r, c, v, lat);
    check("t5_after_result", 32'(r), 32'h30);
    check("t5_after_cout", 32'(c), 32'd0);

`ifdef SERIAL_ADD_OVF_EN
    // 6: signed overflow flag
    do_op(8'h7F, 8'h01, 1'b0, r, c, v, lat);
    check("t6a_result", 32'(r), 32'h80);
    check("t6a_ovf", 32'(v), 32'd1);
    do_op(8'h80, 8'h01, 1'b1, r, c, v, lat);
    check("t6b_result", 32'(r), 32'h7F);
    check("t6b_ovf", 32'(v), 32'd1);
    do_op(8'h01, 8'h01, 1'b0, r, c, v, lat);
    check("t6c_ovf", 32'(v), 32'd0);
`endif

    // Random sweep against an arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      exp9 = {1'b0, ra} + {1'b0, bb} + {8'h00, rs};
      exp_ovf = (ra[7] == bb[7]) && (exp9[7] != ra[7]);
      do_op(ra, rb, rs, r, c, v, lat);
      check("rand_sum", 32'({c, r}), 32'(exp9));
`ifdef SERIAL_ADD_OVF_EN
      check("rand_ovf", 32'(v), 32'(exp_ovf));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
